// File: rtl/mul_pipe_param_if.sv
// Operand/result handshake bundle for mul_pipe_param.
// The producer side takes master; the multiplier takes slave.
interface mul_pipe_param_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   p;
  logic [TAG_W-1:0]     out_tag;

  modport master (
    output in_valid, a, b, signed_mode, in_tag, out_ready,
    input  in_ready, out_valid, p, out_tag
  );

  modport slave (
    input  in_valid, a, b, signed_mode, in_tag, out_ready,
    output in_ready, out_valid, p, out_tag
  );
endinterface

// File: rtl/mul_pipe_param.sv
// Shift-add pipelined multiplier: one partial-product row per stage, signed or
// unsigned per transaction, whole-pipeline stall on output back-pressure.
module mul_pipe_param #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  mul_pipe_param_if.slave bus
);
  localparam int PW = 2 * WIDTH;

  logic                 adv;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic                 mode_in;
  logic [TAG_W-1:0]     tag_in;

  logic [WIDTH-1:0]     valid_q;
  logic [PW-1:0]        sum_q  [WIDTH];
  logic [PW-1:0]        sum_d  [WIDTH];
  logic [TAG_W-1:0]     tag_q  [WIDTH];
  // Operands are only needed by the stages that still have rows to add.
  logic [WIDTH-1:0]     a_q    [WIDTH-1];
  logic [WIDTH-1:0]     b_q    [WIDTH-1];
  logic                 mode_q [WIDTH-1];

  logic                 unused_b;

  // Row = a masked by one multiplier bit, extended to PW bits and weighted.
  function automatic logic [PW-1:0] row_f(
    input logic [WIDTH-1:0] op,
    input logic             sel,
    input logic             sgn,
    input int               sh
  );
    logic [WIDTH-1:0] r;
    logic [PW-1:0]    ext;
    r   = op & {WIDTH{sel}};
    ext = {{WIDTH{sgn & r[WIDTH-1]}}, r};
    return ext << sh;
  endfunction

  assign adv = !valid_q[WIDTH-1] || bus.out_ready;

  // Invalid slots load zeros so bubbles never carry X through the datapath.
  assign a_in    = bus.in_valid ? bus.a : '0;
  assign b_in    = bus.in_valid ? bus.b : '0;
  assign mode_in = bus.in_valid & bus.signed_mode;
  assign tag_in  = bus.in_valid ? bus.in_tag : '0;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sum_d[gi] = row_f(a_in, b_in[0], mode_in, 0);
      end else begin : g_rest
        logic [PW-1:0] row;
        assign row = row_f(a_q[gi-1], b_q[gi-1][gi], mode_q[gi-1], gi);
        if (gi == WIDTH - 1) begin : g_msb
          // The sign-bit row carries negative weight in two's complement.
          assign sum_d[gi] = mode_q[gi-1] ? (sum_q[gi-1] - row)
                                          : (sum_q[gi-1] + row);
        end else begin : g_mid
          assign sum_d[gi] = sum_q[gi-1] + row;
        end
      end
    end
  endgenerate

  assign unused_b = ^b_q[WIDTH-2][WIDTH-2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < WIDTH; k++) begin
        sum_q[k] <= '0;
        tag_q[k] <= '0;
      end
      for (int k = 0; k < WIDTH - 1; k++) begin
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        mode_q[k] <= 1'b0;
      end
    end else if (adv) begin
      valid_q  <= {valid_q[WIDTH-2:0], bus.in_valid};
      tag_q[0] <= tag_in;
      a_q[0]    <= a_in;
      b_q[0]    <= b_in;
      mode_q[0] <= mode_in;
      for (int k = 0; k < WIDTH; k++) begin
        sum_q[k] <= sum_d[k];
      end
      for (int k = 1; k < WIDTH; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      for (int k = 1; k < WIDTH - 1; k++) begin
        a_q[k]    <= a_q[k-1];
        b_q[k]    <= b_q[k-1];
        mode_q[k] <= mode_q[k-1];
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[WIDTH-1];
  assign bus.p         = sum_q[WIDTH-1];
  assign bus.out_tag   = tag_q[WIDTH-1];
endmodule

// File: tb/tb_mul_pipe_param.sv
// Directed and scoreboarded checks of mul_pipe_param at WIDTH=8, TAG_W=4.
module tb_mul_pipe_param;
  localparam int W  = 8;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_pipe_param_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  mul_pipe_param #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q [$];

  logic [7:0]  bb_a [4] = '{8'hFF, 8'h00, 8'hFD, 8'h80};
  logic [7:0]  bb_b [4] = '{8'hFF, 8'hC8, 8'h05, 8'h80};
  logic        bb_m [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [15:0] bb_p [4] = '{16'hFE01, 16'h0000, 16'hFFF1, 16'h4000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic m);
    logic signed [15:0] sx, sy;
    logic [15:0] ux, uy;
    sx = {{8{x[7]}}, x};
    sy = {{8{y[7]}}, y};
    ux = {8'h00, x};
    uy = {8'h00, y};
    if (m) return 16'(sx * sy);
    return ux * uy;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic m, input logic [3:0] t);
    bus.a           = x;
    bus.b           = y;
    bus.signed_mode = m;
    bus.in_tag      = t;
    bus.in_valid    = 1'b1;
  endtask

  task automatic single(input logic [7:0] x, input logic [7:0] y, input logic m,
                        input logic [3:0] t, input logic [15:0] expp, input string name);
    drive(x, y, m, t);
    #1;
    chk({name, "_in_ready"}, bus.in_ready, 1);
    cyc();
    bus.in_valid = 1'b0;
    for (int i = 1; i < W; i++) begin
      cyc();
      if (i < W - 1) chk({name, "_early_valid"}, bus.out_valid, 0);
    end
    chk({name, "_valid"}, bus.out_valid, 1);
    chk({name, "_p"}, bus.p, expp);
    chk({name, "_tag"}, bus.out_tag, t);
    cyc();
    chk({name, "_once"}, bus.out_valid, 0);
  endtask

  task automatic run_stream(input int n, input int hold_len, input int ready_pct,
                            input int max_cyc, input string name);
    int issued = 0;
    int recv = 0;
    int hold_left = 0;
    int cycles = 0;
    bit hold_done = 0;
    bit stalled;
    bit need_new = 1;
    logic [15:0] held_p = '0;
    logic [3:0]  held_t = '0;
    logic [19:0] e;
    exp_q.delete();
    while (recv < n && cycles < max_cyc) begin
      if (issued < n) begin
        if (need_new) begin
          drive(8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
          need_new = 0;
        end
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      if (hold_len > 0 && !hold_done && bus.out_valid) begin
        hold_done = 1;
        hold_left = hold_len;
        held_p    = bus.p;
        held_t    = bus.out_tag;
      end
      stalled = (hold_left > 0);
      if (stalled) begin
        bus.out_ready = 1'b0;
        hold_left--;
      end else begin
        bus.out_ready = ($urandom_range(99, 0) < ready_pct);
      end
      #1;
      chk({name, "_in_ready"}, bus.in_ready, !bus.out_valid || bus.out_ready);
      if (stalled) begin
        chk({name, "_stall_in_ready"}, bus.in_ready, 0);
        chk({name, "_stall_valid"}, bus.out_valid, 1);
        chk({name, "_stall_p"}, bus.p, held_p);
        chk({name, "_stall_tag"}, bus.out_tag, held_t);
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({bus.in_tag, model(bus.a, bus.b, bus.signed_mode)});
        issued++;
        need_new = 1;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk({name, "_result_expected"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk({name, "_p"}, bus.p, e[15:0]);
          chk({name, "_tag"}, bus.out_tag, e[19:16]);
        end
        recv++;
      end
      cyc();
      cycles++;
    end
    chk({name, "_received"}, recv, n);
    chk({name, "_drained"}, exp_q.size(), 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < W; i++) begin
      cyc();
      chk({name, "_no_extra"}, bus.out_valid, 0);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.signed_mode = 1'b0;
    bus.in_tag      = '0;
    bus.out_ready   = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_p", bus.p, 0);
    chk("reset_tag", bus.out_tag, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b0;
    #1;
    chk("empty_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;

    single(8'd13, 8'd11, 1'b0, 4'd3, 16'h008F, "basic");

    // Four corner cases back to back; results must land on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      drive(bb_a[i], bb_b[i], bb_m[i], 4'(i));
      cyc();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < W - 4; i++) cyc();
    for (int i = 0; i < 4; i++) begin
      chk("b2b_valid", bus.out_valid, 1);
      chk("b2b_p", bus.p, bb_p[i]);
      chk("b2b_tag", bus.out_tag, i);
      cyc();
    end
    chk("b2b_drained", bus.out_valid, 0);

    // Same operand bits, unsigned then signed.
    drive(8'hFF, 8'h02, 1'b0, 4'd4);
    cyc();
    drive(8'hFF, 8'h02, 1'b1, 4'd5);
    cyc();
    bus.in_valid = 1'b0;
    for (int i = 0; i < W - 2; i++) cyc();
    chk("mixed_u_valid", bus.out_valid, 1);
    chk("mixed_u_p", bus.p, 16'h01FE);
    chk("mixed_u_tag", bus.out_tag, 4);
    cyc();
    chk("mixed_s_valid", bus.out_valid, 1);
    chk("mixed_s_p", bus.p, 16'hFFFE);
    chk("mixed_s_tag", bus.out_tag, 5);
    cyc();
    chk("mixed_drained", bus.out_valid, 0);

    run_stream(10, 5, 100, 500, "bp");

    // Reset with five transactions in flight and one offered at the reset edge.
    for (int i = 0; i < 5; i++) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
      cyc();
    end
    rst = 1'b1;
    drive(8'd9, 8'd9, 1'b0, 4'd1);
    cyc();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_p", bus.p, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    for (int i = 0; i < W; i++) begin
      cyc();
      chk("midrst_quiet", bus.out_valid, 0);
    end
    single(8'd7, 8'd6, 1'b0, 4'd9, 16'h002A, "post_rst");

    run_stream(10000, 0, 70, 40000, "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_pipe_param.md
# mul_pipe_param

Parametrised shift-add pipelined multiplier, one partial-product row per pipeline stage. It generalises the fixed 4-bit pipelined multiplier to any operand width and adds three things: a per-transaction signed/unsigned mode, a valid/ready handshake with full-pipeline stall, and a sideband tag carried alongside each product. It is the leaf multiplier for the wider recursive multipliers and for datapath units that need back-pressure.

## Interface
- `WIDTH`, 8: operand width in bits, ≥ 2; the product is `2*WIDTH` bits.
- `TAG_W`, 4: width of the sideband tag, ≥ 1.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: operands present.
- `in_ready` output 1: block can accept; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `a` input WIDTH: multiplicand.
- `b` input WIDTH: multiplier.
- `signed_mode` input 1: 1 = both operands are two's complement; 0 = both unsigned.
- `in_tag` input TAG_W: opaque tag, returned with the result.
- `out_valid` output 1: `p` / `out_tag` hold a result.
- `out_ready` input 1: consumer accepts the result.
- `p` output 2*WIDTH: product.
- `out_tag` output TAG_W: tag of the transaction in `p`.

## Operation
- Pipeline has WIDTH register stages S1..SW. Each stage holds:
  - a valid bit;
  - the partial sum;
  - `a`, `b`, `signed_mode` and the tag.
- S1 captures row 0, i.e. `a & {WIDTH{b[0]}}`, extended to the sum width.
- Stage Sk (k ≥ 2) adds row k-1, `(a & {WIDTH{b[k-1]}}) << (k-1)`, to the previous partial sum.
- Unsigned mode: rows are zero-extended and all rows are added.
- Signed mode:
  - rows are sign-extended from `a[WIDTH-1]`;
  - row WIDTH-1 (weight of `b[WIDTH-1]`) is subtracted, not added;
  - the result is the exact two's-complement product modulo 2^(2*WIDTH).
- `p` is the SW partial sum and `out_valid` is the SW valid bit; `out_tag` follows SW.
- Global advance enable: `adv = !out_valid || out_ready`. `in_ready = adv` (combinational).
- When `adv` = 1:
  - every stage loads from its predecessor;
  - S1 loads `in_valid`, the operands and the tag.
- When `adv` = 0, every stage holds its contents, including bubbles.
- Bubbles (valid = 0) propagate normally; the data fields of invalid stages are don't-care but must not be X after reset.
- Operand, mode and tag values are irrelevant when `in_valid` = 0.
- No result is ever dropped or duplicated. Order is strictly FIFO.

## Timing
- Reset (`rst` = 1 at an edge):
  - all valid bits clear;
  - all partial sums, `p` and `out_tag` become 0;
  - `out_valid` = 0;
  - `in_ready` = 1 in the following cycle.
- Reset mid-operation: all in-flight transactions are discarded with no output. A transfer offered during the reset edge is not accepted.
- Latency with no stall:
  - a transfer at edge e0 yields `out_valid` = 1 with its product after edge e0+WIDTH-1;
  - the result is visible for the cycle following that edge;
  - e.g. WIDTH = 8 gives 8 register stages.
- Throughput: one transfer per cycle while `out_ready` = 1.
- Stall: with `out_valid` = 1 and `out_ready` = 0, `in_ready` = 0 and `p` / `out_tag` / `out_valid` stay stable. Each stalled cycle adds one cycle to the latency of every in-flight transaction.
- Simultaneous events:
  - `out_ready` rising with `in_valid` = 1 in the same cycle: the output retires and the input is accepted at the same edge;
  - with the pipeline empty (`out_valid` = 0), `in_ready` = 1 regardless of `out_ready`.
- Width rules:
  - intermediate sums are kept at 2*WIDTH bits with no truncation before SW;
  - the unsigned maximum `(2^WIDTH-1)^2` fits;
  - signed `(-2^(WIDTH-1))^2 = 2^(2*WIDTH-2)` fits without overflow.

## Test plan
All scenarios use WIDTH = 8 and TAG_W = 4.
- Reset, then a=13, b=11, unsigned, tag=3 -> after 8 edges: `p` = 0x008F, `out_tag` = 3, `out_valid` for exactly one cycle with `out_ready` = 1.
- Back-to-back corner cases, all unsigned unless stated, tags 0..3:
  - 255×255 -> 0xFE01 (tag 0);
  - 0×200 -> 0x0000 (tag 1);
  - signed -3×5 -> 0xFFF1 (tag 2);
  - signed -128×-128 -> 0x4000 (tag 3);
  - results appear on 4 consecutive cycles, in order.
- Mixed mode, same bits: a=0xFF, b=0x02 unsigned -> 0x01FE; signed -> 0xFFFE; issued on adjacent cycles.
- Back-pressure:
  - stream 10 random pairs, hold `out_ready` = 0 for 5 cycles starting when the first result is valid;
  - `in_ready` = 0 and `p` stable during the hold;
  - all 10 results correct and in order after release; none lost.
- Reset mid-stream: assert `rst` for 1 cycle with 5 transactions in flight -> `out_valid` stays 0 for the next 8 cycles; a new a=7, b=6 gives `p` = 0x002A at latency 8.
- Random regression: 10k transactions with random mode, operands, tags and `out_ready` -> all compared against a reference model (a×b, signed or unsigned, mod 2^16).
